// File: rtl/seven_seg_scan.sv
// Four-digit multiplexed seven-segment scanner with per-slot blanking and PWM dimming.
// Latency: an_out/seg_out/frame_tick are registered, one cycle behind the scan counters.
// Backpressure: none; free-running scan, inputs sampled once at the start of each slot.
//
// Ports:
//   clk, rst      - system clock, synchronous active-high reset
//   seg_in[27:0]  - decoded segments, digit k in bits [7k+6:7k], bit 7k = segment a, 1 = lit
//   digit_en[3:0] - per-digit enable, 0 = digit stays dark
//   brightness    - duty level 0..15 (0 = 1/16 duty, 15 = full on-phase)
//   an_out[3:0]   - active-low anodes, bit k selects digit k
//   seg_out[6:0]  - active-low cathodes, bit 0 = segment a
//   frame_tick    - one-cycle pulse after the last cycle of digit 3's slot
module seven_seg_scan #(
  parameter int SLOT_CYCLES  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [27:0] seg_in,
  input  logic [3:0]  digit_en,
  input  logic [3:0]  brightness,
  output logic [3:0]  an_out,
  output logic [6:0]  seg_out,
  output logic        frame_tick
);

  localparam int SW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam logic [SW-1:0] SLOT_LAST   = SW'(SLOT_CYCLES - 1);
  localparam logic [SW-1:0] BLANK_START = SW'(BLANK_CYCLES);

  logic [SW-1:0] slot_cnt;
  logic [1:0]    dig_idx;
  logic [3:0]    pwm_cnt;
  logic [6:0]    lat_seg;
  logic [3:0]    lat_en;
  logic [3:0]    lat_bri;

  logic [6:0]    cur_seg;
  logic          in_blank;
  logic          slot_wrap;
  logic          lit;
  logic [3:0]    dig_onehot;

  // Segment field of the digit currently being scanned.
  always_comb begin
    cur_seg = 7'h00;
    case (dig_idx)
      2'd0:    cur_seg = seg_in[6:0];
      2'd1:    cur_seg = seg_in[13:7];
      2'd2:    cur_seg = seg_in[20:14];
      default: cur_seg = seg_in[27:21];
    endcase
  end

  assign in_blank   = (slot_cnt < BLANK_START);
  assign slot_wrap  = (slot_cnt == SLOT_LAST);
  assign dig_onehot = 4'b0001 << dig_idx;
  // Latched values are always fresh by the on-phase since the blank phase is at
  // least one cycle long and latching happens on slot counter 0.
  assign lit        = !in_blank && lat_en[dig_idx] && (pwm_cnt <= lat_bri);

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_cnt   <= '0;
      dig_idx    <= 2'd0;
      pwm_cnt    <= 4'd0;
      lat_seg    <= 7'h00;
      lat_en     <= 4'h0;
      lat_bri    <= 4'h0;
      an_out     <= 4'hF;
      seg_out    <= 7'h7F;
      frame_tick <= 1'b0;
    end else begin
      if (slot_wrap) begin
        slot_cnt <= '0;
        dig_idx  <= dig_idx + 2'd1;
      end else begin
        slot_cnt <= slot_cnt + 1'b1;
      end

      // Held at 0 through the blank phase so the first on-phase cycle sees 0.
      if (in_blank) pwm_cnt <= 4'd0;
      else          pwm_cnt <= pwm_cnt + 4'd1;

      if (slot_cnt == '0) begin
        lat_seg <= cur_seg;
        lat_en  <= digit_en;
        lat_bri <= brightness;
      end

      an_out     <= lit ? ~dig_onehot : 4'hF;
      seg_out    <= lit ? ~lat_seg    : 7'h7F;
      frame_tick <= (dig_idx == 2'd3) && slot_wrap;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan.sv
module tb_seven_seg_scan;

  localparam int SLOT  = 8;
  localparam int BLANK = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [27:0] seg_in;
  logic [3:0]  digit_en;
  logic [3:0]  brightness;
  logic [3:0]  an_out;
  logic [6:0]  seg_out;
  logic        frame_tick;

  int n_chk = 0;
  int n_err = 0;

  seven_seg_scan #(.SLOT_CYCLES(SLOT), .BLANK_CYCLES(BLANK)) dut (
    .clk        (clk),
    .rst        (rst),
    .seg_in     (seg_in),
    .digit_en   (digit_en),
    .brightness (brightness),
    .an_out     (an_out),
    .seg_out    (seg_out),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Holds reset for 3 edges with random segments, then releases with the given settings.
  task automatic do_reset(input logic [27:0] s, input logic [3:0] en, input logic [3:0] b);
    @(negedge clk);
    rst    = 1'b1;
    seg_in = 28'($urandom);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_an", 32'(an_out), 32'hF);
      chk("rst_seg", 32'(seg_out), 32'h7F);
      chk("rst_ft", 32'(frame_tick), 32'h0);
      seg_in = 28'($urandom);
    end
    seg_in     = s;
    digit_en   = en;
    brightness = b;
    rst        = 1'b0;
  endtask

  int tick_cnt;
  int tick_k[$];

  // Output after the k-th edge since release reflects scan position t = k-1.
  task automatic scan(input string tag, input int ncyc);
    int t, slot, dig, pwm;
    logic lit;
    logic [3:0] ea;
    logic [6:0] es;
    tick_cnt = 0;
    tick_k.delete();
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      t    = k - 1;
      slot = t % SLOT;
      dig  = (t / SLOT) % 4;
      pwm  = (slot - BLANK) % 16;
      lit  = (slot >= BLANK) && digit_en[dig] && (pwm <= int'(brightness));
      ea   = lit ? ~(4'b0001 << dig) : 4'hF;
      es   = lit ? ~seg_in[7*dig +: 7] : 7'h7F;
      chk({tag, "_an"}, 32'(an_out), 32'(ea));
      chk({tag, "_seg"}, 32'(seg_out), 32'(es));
      chk({tag, "_ft"}, 32'(frame_tick), 32'((t % (4*SLOT)) == (4*SLOT - 1)));
      chk({tag, "_onelow"}, 32'($countones(~an_out) <= 1), 32'h1);
      if (frame_tick) begin
        tick_cnt++;
        tick_k.push_back(k);
      end
    end
  endtask

  initial begin
    rst = 1'b1; seg_in = '0; digit_en = '0; brightness = '0;

    // Reset, then scan/frame: digit 0 = 0x3F, full brightness, 3 frames.
    do_reset(28'h000003F, 4'hF, 4'd15);
    scan("scan", 96);
    chk("tick_count", 32'(tick_cnt), 32'd3);
    if (tick_k.size() == 3) begin
      chk("tick0", 32'(tick_k[0]), 32'd32);
      chk("tick_gap1", 32'(tick_k[1] - tick_k[0]), 32'd32);
      chk("tick_gap2", 32'(tick_k[2] - tick_k[1]), 32'd32);
    end

    // Enable mask 0101 with four distinct digits.
    do_reset({7'h4F, 7'h5B, 7'h06, 7'h3F}, 4'b0101, 4'd15);
    scan("mask", 32);

    // Dimming at brightness 2 and minimum brightness 0.
    do_reset({7'h4F, 7'h5B, 7'h06, 7'h3F}, 4'hF, 4'd2);
    scan("dim2", 32);
    do_reset({7'h4F, 7'h5B, 7'h06, 7'h3F}, 4'hF, 4'd0);
    scan("dim0", 32);

    // Mid-slot change: new segments must not show until the next slot.
    do_reset({7'h00, 7'h00, 7'h06, 7'h3F}, 4'hF, 4'd15);
    for (int k = 1; k <= 4; k++) @(negedge clk);
    seg_in = {7'h7F, 7'h6D, 7'h4F, 7'h5B};
    for (int k = 5; k <= 8; k++) begin
      @(negedge clk);
      chk("mid_an", 32'(an_out), 32'hE);
      chk("mid_seg", 32'(seg_out), 32'h40);
    end
    for (int k = 9; k <= 10; k++) begin
      @(negedge clk);
      chk("mid_blank", 32'(an_out), 32'hF);
    end
    @(negedge clk);
    chk("mid_next_an", 32'(an_out), 32'hD);
    chk("mid_next_seg", 32'(seg_out), 32'h30);

    // Advance into digit 2's on-phase, then pulse reset.
    for (int k = 12; k <= 20; k++) @(negedge clk);
    chk("pre_rst_an", 32'(an_out), 32'hB);
    rst = 1'b1;
    @(negedge clk);
    chk("prst_an", 32'(an_out), 32'hF);
    chk("prst_seg", 32'(seg_out), 32'h7F);
    chk("prst_ft", 32'(frame_tick), 32'h0);
    rst = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      chk("prst_blank_an", 32'(an_out), 32'hF);
      chk("prst_blank_seg", 32'(seg_out), 32'h7F);
    end
    @(negedge clk);
    chk("prst_d0_an", 32'(an_out), 32'hE);
    chk("prst_d0_seg", 32'(seg_out), 32'h24);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan.md
SEVEN_SEG_SCAN -- requirements
Module: seven_seg_scan

Interface
REQ-001 Parameter: SLOT_CYCLES, default 50000, clock cycles per digit time slot; SHALL be at least BLANK_CYCLES+1.
REQ-002 Parameter: BLANK_CYCLES, default 500, blanked cycles at the start of each slot; SHALL be at least 1.
REQ-003 Port: clk  input  1  single system clock; all state SHALL update on its rising edge only.
REQ-004 Port: rst  input  1  reset; synchronous and active-high.
REQ-005 Port: seg_in  input  28  decoded segments for four digits.
- Digit k occupies bits [7k+6:7k].
- Bit 7k drives segment a.
- 1 = segment lit.
REQ-006 Port: digit_en  input  4  per-digit enable; 0 = digit dark.
REQ-007 Port: brightness  input  4  duty level 0..15.
REQ-008 Port: an_out  output  4  digit anodes, active-low; bit k selects digit k.
REQ-009 Port: seg_out  output  7  segment cathodes, active-low; bit 0 = segment a.
REQ-010 Port: frame_tick  output  1  one-cycle pulse at the end of each 4-digit frame.

Function
REQ-011 Slot counter
- Counts 0..SLOT_CYCLES-1 and SHALL wrap to 0.
- Digit index SHALL increment on each wrap, sequence 0,1,2,3,0.
REQ-012 Slot-start sampling
- When the slot counter is 0, the block SHALL latch:
  - seg_in bits for the current digit index;
  - digit_en;
  - brightness.
- Changes to these inputs at any other point in the slot SHALL have no effect until the next slot.
REQ-013 Blank phase
- Slot counter in 0..BLANK_CYCLES-1.
- an_out SHALL be 4'hF and seg_out SHALL be 7'h7F.
REQ-014 On phase
- Slot counter in BLANK_CYCLES..SLOT_CYCLES-1.
- A 4-bit PWM counter SHALL start at 0 on the first on-phase cycle.
- It SHALL increment by 1 each cycle, wrapping modulo 16.
REQ-015 Lit condition
- A digit is lit when both hold: its latched digit_en bit is 1, and PWM counter <= latched brightness.
- brightness 0 gives 1/16 duty; brightness 15 gives full duty.
REQ-016 Lit cycle
- an_out SHALL have only bit [index] low.
- seg_out SHALL be the bitwise inverse of the latched digit segments.
REQ-017 Unlit on-phase cycle
- an_out SHALL be 4'hF and seg_out SHALL be 7'h7F.
- At most one an_out bit SHALL ever be low.
REQ-018 Output registers
- an_out, seg_out and frame_tick SHALL be registered.
- Outputs SHALL reflect counter state with exactly one cycle of latency.
REQ-019 frame_tick
- SHALL be high for exactly one cycle.
- That cycle SHALL immediately follow the cycle in which digit index 3 and slot counter SLOT_CYCLES-1 occur together.
REQ-020 Reset precedence
- rst SHALL take priority over counter wrap.
- rst asserted on the same cycle as a wrap SHALL produce reset state, not an advance.

Reset
REQ-021 While rst is high at a rising edge, the next cycle SHALL have all of:
- slot counter, digit index and PWM counter at 0;
- latched segments, enables and brightness at 0;
- an_out 4'hF, seg_out 7'h7F, frame_tick 0.
REQ-022 Reset mid-frame SHALL abandon the current slot. After release, scanning SHALL restart at digit 0, beginning with a full blank phase.
REQ-023 The first cycle after rst deasserts SHALL be slot counter 0, digit 0, with sampling per REQ-012.

Verification (SLOT_CYCLES=8, BLANK_CYCLES=2)
REQ-024 Reset: rst high for 3 cycles, with random seg_in.
- Required: an_out=4'hF, seg_out=7'h7F and frame_tick=0 throughout, and for 2 cycles after release.
REQ-025 Scan: seg_in=28'h0000_03F (digit0=7'h3F, others 0), digit_en=4'hF, brightness=15.
- Digit 0 slot: 2 blank cycles, then 6 cycles of an_out=4'hE, seg_out=7'h40.
- Digit 1 slot: 6 cycles of an_out=4'hD, seg_out=7'h7F.
REQ-026 Frame: free run for 96 cycles.
- Required: frame_tick high exactly 3 times, 32 cycles apart, each 1 cycle wide.
- Required: an_out never has more than one low bit.
REQ-027 Enable mask: digit_en=4'b0101.
- Required: an_out=4'hF for the entire digit 1 and digit 3 slots.
- Required: digits 0 and 2 light as in REQ-025.
REQ-028 Dimming: brightness=2.
- Required: each slot gives 2 blank cycles, then 3 lit cycles (PWM 0..2), then 3 dark cycles.
REQ-029 Mid-slot change and reset.
- seg_in changed at slot counter 4: seg_out SHALL be unchanged until the next slot.
- rst pulsed at digit 2: next slot SHALL be digit 0, with an_out=4'hE after 2 blank cycles.
